// File: rtl/debounce_bit.sv
// Single-channel debouncer: 2-flop synchronizer, stability counter,
// registered level plus one-cycle rise/fall pulses.
module debounce_bit #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  // Narrowest counter that can hold STABLE_CYCLES-1.
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s0;
  logic             s1;
  logic [CNT_W-1:0] cnt;

  // Synchronize the raw level, count consecutive mismatches, and flip the
  // output once the mismatch has lasted STABLE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      cnt  <= '0;
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s0   <= in;
      s1   <= s0;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s1 != out) begin
        if (cnt == CNT_MAX) begin
          out  <= s1;
          cnt  <= '0;
          rise <= s1;
          fall <= ~s1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any return to the current level restarts the stability window.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/debounce8.sv
// Eight independent debounce channels plus a combined activity flag.
module debounce8 #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic [7:0] rise,
  output logic [7:0] fall,
  output logic       any
);

  // One fully independent debouncer per channel.
  for (genvar i = 0; i < 8; i++) begin : g_ch
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .in    (in[i]),
      .out   (out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Straight from the out registers so downstream sees no added latency.
  assign any = |out;

endmodule

// File: tb/tb_debounce8.sv
module tb_debounce8;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       any;

  int checks = 0;
  int failures = 0;
  logic done = 1'b0;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       any;
  } exp_t;

  exp_t exp_q[$];

  debounce8 #(.STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .out   (dout),
    .rise  (rise),
    .fall  (fall),
    .any   (any)
  );

  always #5 clk = ~clk;

  // Reference model: each channel sees its input two edges late; once the
  // delayed level has disagreed with the debounced level for SC edges in a
  // row, the debounced level takes it and a pulse is emitted.
  initial begin : model
    logic [7:0] seen_1;   // input sampled one edge ago
    logic [7:0] seen_2;   // input sampled two edges ago
    logic [7:0] lvl;
    logic [7:0] r;
    logic [7:0] f;
    int         run [8];
    exp_t       e;
    seen_1 = '0;
    seen_2 = '0;
    lvl    = '0;
    for (int i = 0; i < 8; i++) run[i] = 0;
    forever begin
      @(posedge clk);
      r = '0;
      f = '0;
      if (reset) begin
        seen_1 = '0;
        seen_2 = '0;
        lvl    = '0;
        for (int i = 0; i < 8; i++) run[i] = 0;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (seen_2[i] != lvl[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == SC) begin
              lvl[i] = seen_2[i];
              r[i]   = seen_2[i];
              f[i]   = ~seen_2[i];
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
        seen_2 = seen_1;
        seen_1 = din;
      end
      e.out  = lvl;
      e.rise = r;
      e.fall = f;
      e.any  = |lvl;
      exp_q.push_back(e);
    end
  end

  // Monitor: the DUT presents a result every cycle; pop and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: no expected entry at time %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e.out || rise !== e.rise || fall !== e.fall || any !== e.any) begin
            failures++;
            $display("FAIL sb_cycle t=%0t: got out=%h rise=%h fall=%h any=%b, expected out=%h rise=%h fall=%h any=%b",
                     $time, dout, rise, fall, any, e.out, e.rise, e.fall, e.any);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic clean_reset();
    reset = 1'b1;
    din   = 8'h00;
    repeat (2) edge_();
    reset = 1'b0;
  endtask

  initial begin : stim
    int cyc;
    int hold;

    // Input held high through reset, then released.
    reset = 1'b1;
    din   = 8'hFF;
    repeat (3) begin
      edge_();
      chk("rst_out", dout, 8'h00);
      chk("rst_any", {7'b0, any}, 8'h00);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      edge_();
      if (k < 6) begin
        chk("rel_out_hold", dout, 8'h00);
        chk("rel_rise_quiet", rise, 8'h00);
      end else begin
        chk("rel_out_flip", dout, 8'hFF);
        chk("rel_rise_pulse", rise, 8'hFF);
      end
    end
    repeat (3) begin
      edge_();
      chk("rel_rise_once", rise, 8'h00);
      chk("rel_any", {7'b0, any}, 8'h01);
    end

    // Glitch shorter than the stability window.
    clean_reset();
    din[0] = 1'b1;
    repeat (3) edge_();
    din[0] = 1'b0;
    repeat (10) begin
      edge_();
      chk("glitch_out", dout, 8'h00);
      chk("glitch_rise", rise, 8'h00);
      chk("glitch_fall", fall, 8'h00);
    end

    // Bounce on channel 3, then a steady high.
    clean_reset();
    for (int j = 0; j < 10; j++) begin
      din[3] = (j % 2 == 0);
      repeat (2) begin
        edge_();
        chk("bounce_out", dout, 8'h00);
      end
    end
    din[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      edge_();
      if (k < 6) chk("bounce_settle_hold", dout, 8'h00);
      else begin
        chk("bounce_out_rise", dout, 8'h08);
        chk("bounce_rise_pulse", rise, 8'h08);
      end
    end
    edge_();
    chk("bounce_rise_once", rise, 8'h00);

    // Reset in the middle of a count on channel 2.
    clean_reset();
    din[2] = 1'b1;
    repeat (3) begin
      edge_();
      chk("midrst_pre", dout, 8'h00);
    end
    reset = 1'b1;
    edge_();
    chk("midrst_in_rst", dout, 8'h00);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      edge_();
      if (k < 6) chk("midrst_hold", dout, 8'h00);
      else begin
        chk("midrst_out", dout, 8'h04);
        chk("midrst_rise", rise, 8'h04);
      end
    end

    // Release of channel 7 while channel 0 stays high.
    clean_reset();
    din = 8'h81;
    repeat (6) edge_();
    chk("rel7_setup", dout, 8'h81);
    din = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      edge_();
      chk("rel7_any", {7'b0, any}, 8'h01);
      if (k < 6) chk("rel7_fall_quiet", fall, 8'h00);
      else begin
        chk("rel7_fall_pulse", fall, 8'h80);
        chk("rel7_out", dout, 8'h01);
      end
    end
    edge_();
    chk("rel7_fall_once", fall, 8'h00);
    chk("rel7_rise_none", rise, 8'h00);

    // Random levels held for 1-10 cycles; the monitor checks every cycle.
    cyc = 0;
    while (cyc < 10000) begin
      din  = 8'($urandom);
      hold = $urandom_range(10, 1);
      repeat (hold) edge_();
      cyc += hold;
    end
    if (failures == 0) $display("random phase passed");

    edge_();
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
